centronics_printer_rx: RTL and testbench
========================================

Name: centronics_printer_rx

Overview:
- Printer-side responder for the MSX Centronics port, emulating a parallel printer.
- Data comes from the port 0x91 latch; strobe comes from port 0x90 bit 0.
- It qualifies the strobe, captures the data byte, drives BUSY (returned on port 0x90 bit 1 read) and an ACK pulse, and buffers bytes in a FIFO.
- A valid/ready stream delivers the buffered bytes to a downstream consumer (file/UART/OSD).

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 bytes
STB_MIN, 4, minimum strobe-low width in clk_i cycles for a byte to be accepted (>=1)
ACK_LEN, 32, ack_n_o low width in clk_i cycles (>=1)

Ports:
clk_i  in  1  system clock; single clock domain
reset_n_i  in  1  asynchronous active-low reset
pdata_i  in  8  printer data lines
pstb_n_i  in  1  printer strobe, active low
busy_o  out  1  printer busy, active high
ack_n_o  out  1  acknowledge pulse, active low
out_data_o  out  8  FIFO head byte
out_valid_o  out  1  FIFO not empty
out_ready_i  in  1  consumer accepts head byte
level_o  out  DEPTH_LOG2+1  FIFO occupancy
overrun_o  out  8  count of strobes rejected while busy; saturates at 255

Behaviour:
- Reset (async, reset_n_i low): state IDLE, busy_o=0, ack_n_o=1, out_valid_o=0, out_data_o=0, level_o=0, overrun_o=0, FIFO emptied, strobe history register=1. Any transfer in progress is discarded.
- pstb_n_i is registered once (stb_q). Falling edge = stb_q=1 & pstb_n_i=0. Rising edge = stb_q=0 & pstb_n_i=1.
- IDLE:
  - busy_o=0, ack_n_o=1.
  - On falling edge: go to STB_LOW, low counter=1, hold register<=pdata_i.
- STB_LOW:
  - busy_o=1.
  - While pstb_n_i=0: hold<=pdata_i each cycle, so the last low-cycle value wins; counter increments, saturating at STB_MIN.
  - On the edge sampling pstb_n_i=1 with counter<STB_MIN: glitch; return to IDLE with no capture and no count change.
  - On the edge sampling pstb_n_i=1 with counter>=STB_MIN:
    - FIFO not full: write hold into FIFO on that same edge and enter ACK.
    - FIFO full: enter WAIT_SPACE.
- WAIT_SPACE:
  - busy_o=1, ack_n_o=1; hold retained.
  - Full is evaluated from registered level. The first edge where level_o < 2^DEPTH_LOG2 writes hold and enters ACK.
  - A pop on edge N enables the write on edge N+1.
- ACK:
  - ack_n_o=0 and busy_o=1 for exactly ACK_LEN cycles; then IDLE, ack_n_o=1, busy_o=0.
- Overrun:
  - A falling edge on pstb_n_i while in ACK or WAIT_SPACE increments overrun_o (saturating at 255).
  - That byte is discarded; the state and its timers are unaffected.
  - A falling edge in STB_LOW cannot occur.
- Latency: the byte is visible on out_data_o with out_valid_o=1 immediately after the write edge, provided the FIFO was empty.
- FIFO:
  - First-word-fallthrough; pop on out_valid_o & out_ready_i.
  - out_ready_i while empty has no effect.
  - Simultaneous push and pop: level unchanged, order preserved.
  - Read and write pointers wrap modulo 2^DEPTH_LOG2.
  - level_o counts 0..2^DEPTH_LOG2 inclusive.
- Outputs busy_o and ack_n_o are registered, with no combinational path from inputs.
- Byte order out equals accepted strobe order; no byte is ever duplicated or dropped except rejected glitches and overruns.

Test Plan:
- Reset, then pdata_i=0x41, strobe low 6 cycles, release:
  - busy_o=1 from the cycle after the falling edge.
  - out_valid_o=1 with out_data_o=0x41 right after the release edge.
  - ack_n_o low exactly 32 cycles, then busy_o=0; level_o=1.
- Strobe low 2 cycles (STB_MIN=4) with data 0x55: busy_o rises then clears, out_valid_o stays 0, level_o=0, overrun_o=0.
- With out_ready_i=0, send 17 bytes 0x00..0x10:
  - First 16 fill the FIFO (level_o=16); the 17th holds busy_o=1 in WAIT_SPACE.
  - Pulse out_ready_i one cycle: 0x00 pops; the next edge writes 0x10; ACK pulse follows; level_o=16.
- During ACK of byte 0x20, issue another 5-cycle strobe with 0x21: overrun_o=1, only 0x20 appears in the FIFO, and ACK length is unchanged at 32.
- Continuous out_ready_i=1 with back-to-back bytes 0x30,0x31,0x32: stream order 0x30,0x31,0x32; level_o never exceeds 1.
- Assert reset_n_i low mid-ACK with 3 bytes queued: all outputs return to reset values asynchronously; after release, a new byte 0x7E is accepted normally.

Source files
------------

// File: rtl/centronics_printer_rx.sv
// Printer-side Centronics responder: qualifies the host strobe, captures the byte,
// drives BUSY/ACK handshakes and buffers accepted bytes in a first-word-fallthrough FIFO.
module centronics_printer_rx #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned STB_MIN    = 4,
  parameter int unsigned ACK_LEN    = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [7:0]            pdata_i,
  input  logic                  pstb_n_i,
  output logic                  busy_o,
  output logic                  ack_n_o,
  output logic [7:0]            out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic [7:0]            overrun_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned SW    = $clog2(STB_MIN + 1);
  localparam int unsigned AW    = $clog2(ACK_LEN + 1);

  typedef enum logic [1:0] {IDLE, STB_LOW, WAIT_SPACE, ACK} state_t;

  state_t                  state_q, state_d;
  logic                    stb_q;
  logic [SW-1:0]           low_cnt_q, low_cnt_d;
  logic [AW-1:0]           ack_cnt_q, ack_cnt_d;
  logic [7:0]              hold_q, hold_d;
  logic [7:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [7:0]              ovr_q;
  logic                    busy_q, ack_n_q, valid_q;
  logic                    push, pop, full, fall, ovr_hit;

  assign fall    = stb_q & ~pstb_n_i;
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = valid_q & out_ready_i;
  assign ovr_hit = fall & ((state_q == ACK) | (state_q == WAIT_SPACE));

  // Handshake sequencing: strobe qualification, capture, space wait, ACK pulse
  always_comb begin
    state_d   = state_q;
    low_cnt_d = low_cnt_q;
    ack_cnt_d = ack_cnt_q;
    hold_d    = hold_q;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = STB_LOW;
          low_cnt_d = SW'(1);
          hold_d    = pdata_i;
        end
      end
      STB_LOW: begin
        if (!pstb_n_i) begin
          hold_d = pdata_i;
          if (low_cnt_q < SW'(STB_MIN)) low_cnt_d = low_cnt_q + SW'(1);
        end else if (low_cnt_q < SW'(STB_MIN)) begin
          state_d = IDLE;
        end else if (!full) begin
          push      = 1'b1;
          state_d   = ACK;
          ack_cnt_d = '0;
        end else begin
          state_d = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (!full) begin
          push      = 1'b1;
          state_d   = ACK;
          ack_cnt_d = '0;
        end
      end
      ACK: begin
        if (ack_cnt_q == AW'(ACK_LEN - 1)) state_d = IDLE;
        else ack_cnt_d = ack_cnt_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      stb_q     <= 1'b1;
      low_cnt_q <= '0;
      ack_cnt_q <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      ack_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      stb_q     <= pstb_n_i;
      low_cnt_q <= low_cnt_d;
      ack_cnt_q <= ack_cnt_d;
      hold_q    <= hold_d;
      busy_q    <= (state_d != IDLE);
      ack_n_q   <= (state_d != ACK);
    end
  end

  // FIFO storage, pointers and occupancy; overrun counter saturates
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= hold_q;
        wr_ptr_q        <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      level_q <= level_d;
      valid_q <= (level_d != '0);
      if (ovr_hit && (ovr_q != 8'hFF)) ovr_q <= ovr_q + 8'd1;
    end
  end

  assign busy_o      = busy_q;
  assign ack_n_o     = ack_n_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = mem_q[rd_ptr_q];
  assign level_o     = level_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_centronics_printer_rx.sv
// Scoreboard bench for centronics_printer_rx: directed handshake scenarios plus random strobes.
module tb_centronics_printer_rx;
  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int unsigned STB_MIN    = 4;
  localparam int unsigned ACK_LEN    = 32;
  localparam int unsigned DEPTH      = 16;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [7:0] pdata_i = 8'h00;
  logic       pstb_n_i = 1'b1;
  logic       out_ready_i = 1'b0;
  logic       busy_o, ack_n_o, out_valid_o;
  logic [7:0] out_data_o, overrun_o;
  logic [DEPTH_LOG2:0] level_o;

  centronics_printer_rx #(.DEPTH_LOG2(DEPTH_LOG2), .STB_MIN(STB_MIN), .ACK_LEN(ACK_LEN)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .pdata_i(pdata_i), .pstb_n_i(pstb_n_i),
    .busy_o(busy_o), .ack_n_o(ack_n_o), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .level_o(level_o), .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  bit         rand_rdy = 1'b0;
  bit         track = 1'b0;
  int         lvl_max = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head byte must match the oldest expected byte
  always @(negedge clk_i) begin
    if (reset_n_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", out_data_o);
      end else begin
        exp_b = exp_q.pop_front();
        chk("stream_byte", 32'(out_data_o), 32'(exp_b));
      end
    end
    if (track && int'(level_o) > lvl_max) lvl_max = int'(level_o);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 400) begin
      tick();
      t++;
    end
    chk("idle_timeout", 32'(busy_o), 32'd0);
  endtask

  // Host-side byte transfer: a strobe of w low cycles is accepted iff w >= STB_MIN
  task automatic send(input logic [7:0] d, input int w);
    wait_idle();
    pdata_i  = d;
    pstb_n_i = 1'b0;
    repeat (w) tick();
    pstb_n_i = 1'b1;
    tick();
    if (w >= int'(STB_MIN)) exp_q.push_back(d);
  endtask

  task automatic drain();
    int t = 0;
    rand_rdy    = 1'b0;
    out_ready_i = 1'b1;
    while (exp_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    tick();
    tick();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_level", 32'(level_o), 32'd0);
    out_ready_i = 1'b0;
  endtask

  initial begin
    int ack_cnt;
    int t;
    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ack_n", 32'(ack_n_o), 32'd1);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    reset_n_i = 1'b1;
    tick();

    // Basic capture with 6-cycle strobe
    pdata_i  = 8'h41;
    pstb_n_i = 1'b0;
    tick();
    chk("t1_busy_after_fall", 32'(busy_o), 32'd1);
    repeat (5) tick();
    pstb_n_i = 1'b1;
    tick();
    exp_q.push_back(8'h41);
    chk("t1_valid", 32'(out_valid_o), 32'd1);
    chk("t1_data", 32'(out_data_o), 32'h41);
    ack_cnt = 0;
    t = 0;
    while (!ack_n_o && t < 100) begin
      ack_cnt++;
      tick();
      t++;
    end
    chk("t1_ack_len", 32'(ack_cnt), 32'(ACK_LEN));
    chk("t1_busy_clear", 32'(busy_o), 32'd0);
    chk("t1_level", 32'(level_o), 32'd1);
    drain();

    // Glitch: 2-cycle strobe must be ignored
    pdata_i  = 8'h55;
    pstb_n_i = 1'b0;
    tick();
    chk("t2_busy_rise", 32'(busy_o), 32'd1);
    tick();
    pstb_n_i = 1'b1;
    tick();
    tick();
    chk("t2_busy_clear", 32'(busy_o), 32'd0);
    chk("t2_valid", 32'(out_valid_o), 32'd0);
    chk("t2_level", 32'(level_o), 32'd0);
    chk("t2_overrun", 32'(overrun_o), 32'd0);

    // Fill FIFO, 17th byte waits for space
    for (int i = 0; i < int'(DEPTH); i++) send(8'(i), 5);
    wait_idle();
    chk("t3_level_full", 32'(level_o), 32'(DEPTH));
    pdata_i  = 8'h10;
    pstb_n_i = 1'b0;
    repeat (5) tick();
    pstb_n_i = 1'b1;
    tick();
    exp_q.push_back(8'h10);
    tick();
    tick();
    chk("t3_wait_busy", 32'(busy_o), 32'd1);
    chk("t3_wait_ack_n", 32'(ack_n_o), 32'd1);
    chk("t3_wait_level", 32'(level_o), 32'(DEPTH));
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    chk("t3_after_pop_level", 32'(level_o), 32'(DEPTH - 1));
    tick();
    chk("t3_write_level", 32'(level_o), 32'(DEPTH));
    chk("t3_write_ack_n", 32'(ack_n_o), 32'd0);
    wait_idle();
    drain();

    // Overrun during ACK
    pdata_i  = 8'h20;
    pstb_n_i = 1'b0;
    repeat (6) tick();
    pstb_n_i = 1'b1;
    tick();
    exp_q.push_back(8'h20);
    ack_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (!ack_n_o) ack_cnt++;
      tick();
    end
    pdata_i  = 8'h21;
    pstb_n_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!ack_n_o) ack_cnt++;
      tick();
    end
    pstb_n_i = 1'b1;
    t = 0;
    while (!ack_n_o && t < 100) begin
      ack_cnt++;
      tick();
      t++;
    end
    chk("t4_ack_len", 32'(ack_cnt), 32'(ACK_LEN));
    chk("t4_overrun", 32'(overrun_o), 32'd1);
    chk("t4_level", 32'(level_o), 32'd1);
    repeat (3) tick();
    chk("t4_idle_after", 32'(busy_o), 32'd0);
    drain();

    // Streaming with consumer always ready
    out_ready_i = 1'b1;
    lvl_max = 0;
    track = 1'b1;
    send(8'h30, 5);
    send(8'h31, 5);
    send(8'h32, 5);
    wait_idle();
    repeat (3) tick();
    track = 1'b0;
    chk("t5_level_max_le1", 32'(lvl_max <= 1), 32'd1);
    chk("t5_all_streamed", 32'(exp_q.size()), 32'd0);
    out_ready_i = 1'b0;

    // Asynchronous reset mid-ACK with bytes queued
    send(8'h61, 5);
    send(8'h62, 5);
    send(8'h63, 5);
    repeat (3) tick();
    chk("t6_pre_ack", 32'(ack_n_o), 32'd0);
    #2;
    reset_n_i = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_busy", 32'(busy_o), 32'd0);
    chk("t6_ack_n", 32'(ack_n_o), 32'd1);
    chk("t6_valid", 32'(out_valid_o), 32'd0);
    chk("t6_data", 32'(out_data_o), 32'd0);
    chk("t6_level", 32'(level_o), 32'd0);
    chk("t6_overrun", 32'(overrun_o), 32'd0);
    tick();
    tick();
    reset_n_i = 1'b1;
    tick();
    send(8'h7E, 5);
    chk("t6_new_valid", 32'(out_valid_o), 32'd1);
    chk("t6_new_data", 32'(out_data_o), 32'h7E);
    wait_idle();
    drain();

    // Random strobe widths, data and consumer backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) send(8'($urandom_range(0, 255)), int'($urandom_range(1, 8)));
    wait_idle();
    drain();
    chk("rand_overrun", 32'(overrun_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
